// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder reusing a DIGIT-bit full-adder slice, LSB digit first
// Optional feature macro: SERIAL_ADDER_SUB_EN (adds sub port, s = a - b - ci when sub=1)
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset, aborts any operation
//   start launch request, sampled only while busy=0
//   a, b  WIDTH-bit operands, ci carry-in (borrow-in when subtracting), captured on accept
//   sub   subtract select (SERIAL_ADDER_SUB_EN only), captured on accept
//   busy  operation in progress
//   done  one-cycle pulse when s/co are updated
//   s, co registered sum and carry-out
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = N > 1 ? $clog2(N) : 1;
    if (WIDTH < 1 || DIGIT < 1 || WIDTH % DIGIT != 0) begin : g_bad
        $error("serial_adder: WIDTH must be >= 1 and a multiple of DIGIT");
    end
    typedef enum logic {IDLE, RUN} state_t;
    state_t           state;
    logic [WIDTH-1:0] ra, rb, rr;
    logic             c;
    logic [CW-1:0]    cnt;
    logic [DIGIT:0]   sum;
    logic [WIDTH+DIGIT-1:0] cat;
    logic             last;
    // cat shifts the new digit in at the top; works even when DIGIT == WIDTH
    always_comb begin
        sum  = {1'b0, ra[DIGIT-1:0]} + {1'b0, rb[DIGIT-1:0]} + {{DIGIT{1'b0}}, c};
        cat  = {sum[DIGIT-1:0], rr};
        last = cnt == CW'(N - 1);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            s     <= '0;
            co    <= 1'b0;
            ra    <= '0;
            rb    <= '0;
            rr    <= '0;
            c     <= 1'b0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    ra    <= a;
`ifdef SERIAL_ADDER_SUB_EN
                    rb    <= sub ? ~b : b;
                    c     <= sub ? ~ci : ci;
`else
                    rb    <= b;
                    c     <= ci;
`endif
                    cnt   <= '0;
                    busy  <= 1'b1;
                    state <= RUN;
                end
            end else begin
                ra  <= ra >> DIGIT;
                rb  <= rb >> DIGIT;
                rr  <= cat[WIDTH+DIGIT-1:DIGIT];
                c   <= sum[DIGIT];
                cnt <= cnt + 1'b1;
                if (last) begin
                    s     <= cat[WIDTH+DIGIT-1:DIGIT];
                    co    <= sum[DIGIT];
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed checks of serial_adder with DIGIT=1, 4 and 8 at WIDTH=8
module tb_serial_adder;
    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, ci = 1'b0, sub = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic [1:0] sel = '0;
    logic [2:0] busy, done, co;
    logic [7:0] s [3];
    logic       busy_o, done_o, co_o;
    logic [7:0] s_o;
    int         checks = 0, errors = 0;
    always #5 clk = ~clk;
    assign busy_o = busy[sel];
    assign done_o = done[sel];
    assign co_o   = co[sel];
    assign s_o    = s[sel];
    serial_adder #(.WIDTH(8), .DIGIT(1)) u1 (
        .clk(clk), .rst(rst), .start(start && sel == 2'd0), .a(a), .b(b), .ci(ci),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .busy(busy[0]), .done(done[0]), .s(s[0]), .co(co[0]));
    serial_adder #(.WIDTH(8), .DIGIT(4)) u4 (
        .clk(clk), .rst(rst), .start(start && sel == 2'd1), .a(a), .b(b), .ci(ci),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .busy(busy[1]), .done(done[1]), .s(s[1]), .co(co[1]));
    serial_adder #(.WIDTH(8), .DIGIT(8)) u8 (
        .clk(clk), .rst(rst), .start(start && sel == 2'd2), .a(a), .b(b), .ci(ci),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .busy(busy[2]), .done(done[2]), .s(s[2]), .co(co[2]));
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic launch(input logic [1:0] u, input logic [7:0] av, input logic [7:0] bv,
                          input logic civ, input logic sv);
        sel = u; a = av; b = bv; ci = civ; sub = sv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = 8'hxx; b = 8'hxx;
        chk("busy_accept", busy_o, 1);
    endtask
    task automatic wait_done(input string tag, input int exp_k, input logic [7:0] es, input logic eco);
        int k = 0, bcnt = 0;
        logic [7:0] hs = s_o;
        logic hc = co_o, moved = 1'b0;
        while (!done_o && k < 40) begin
            @(posedge clk); #1;
            k++;
            if (!done_o) begin
                bcnt += busy_o ? 1 : 0;
                moved |= (s_o !== hs) || (co_o !== hc);
            end
        end
        chk({tag, "_lat"}, k, exp_k);
        chk({tag, "_busycnt"}, bcnt, exp_k - 1);
        chk({tag, "_hold"}, moved, 0);
        chk({tag, "_s"}, s_o, es);
        chk({tag, "_co"}, co_o, eco);
        chk({tag, "_busy_end"}, busy_o, 0);
    endtask
    initial begin
        int nd;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sel = 2'(i);
            #0;
            chk("rst_busy", busy_o, 0);
            chk("rst_done", done_o, 0);
            chk("rst_s", s_o, 0);
            chk("rst_co", co_o, 0);
        end
        launch(0, 8'hFF, 8'h01, 0, 0);
        wait_done("wrap8", 8, 8'h00, 1);
        @(posedge clk); #1;
        chk("done_pulse_once", done_o, 0);
        launch(0, 8'h5A, 8'h3C, 1, 0);
        wait_done("cin8", 8, 8'h97, 0);
        launch(1, 8'hF0, 8'h10, 0, 0);
        wait_done("wrap4", 2, 8'h00, 1);
        launch(1, 8'h01, 8'h02, 0, 0);
        chk("b2b_done_drop", done_o, 0);
        wait_done("b2b4", 2, 8'h03, 0);
        launch(2, 8'h80, 8'h80, 1, 0);
        wait_done("full8", 1, 8'h01, 1);
        launch(0, 8'h01, 8'h01, 0, 0);
        repeat (3) @(posedge clk);
        #1 a = 8'hFF; b = 8'hFF; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done("ignore", 4, 8'h02, 0);
        nd = 0;
        repeat (12) begin
            @(posedge clk); #1;
            nd += done_o ? 1 : 0;
        end
        chk("ignore_extra_done", nd, 0);
        chk("ignore_not_queued", busy_o, 0);
        launch(0, 8'h33, 8'h44, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1; start = 1'b1; a = 8'h12; b = 8'h34;
        @(posedge clk); #1 rst = 1'b0; start = 1'b0;
        chk("abort_busy", busy_o, 0);
        chk("abort_done", done_o, 0);
        chk("abort_s", s_o, 0);
        chk("abort_co", co_o, 0);
        nd = 0;
        repeat (12) begin
            @(posedge clk); #1;
            nd += done_o ? 1 : 0;
        end
        chk("abort_no_done", nd, 0);
        launch(0, 8'h12, 8'h34, 0, 0);
        wait_done("after_abort", 8, 8'h46, 0);
`ifdef SERIAL_ADDER_SUB_EN
        launch(0, 8'h10, 8'h01, 0, 1);
        wait_done("sub_nb", 8, 8'h0F, 1);
        launch(0, 8'h00, 8'h01, 0, 1);
        wait_done("sub_borrow", 8, 8'hFF, 0);
        launch(1, 8'h10, 8'h01, 1, 1);
        wait_done("sub_bin4", 2, 8'h0E, 1);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
